// File: rtl/spi_reg_peripheral_if.sv
// rtl/spi_reg_peripheral_if.sv - SPI pin bundle between host-side driver and register target
interface spi_reg_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - write-only SPI mode-0 target for the five control registers
module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4,
    parameter int NUM_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_reg_peripheral_if.slave  spi,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle
);
    localparam int CW = $clog2(NUM_BITS + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [6:0] MAX_ADDR_W = 7'(MAX_ADDR);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   copi_dly_q, copi_dly_d;
    logic                   ncs_dly_q,  ncs_dly_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic                   armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_BITS-1:0]    shreg_q, shreg_d;
    logic                   overrun_q, overrun_d;
    logic [4:0][7:0]        regs_q, regs_d;

    logic       sclk_s, ncs_s;
    logic       sclk_rise, ncs_rise, ncs_fall;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       write_ok;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s      = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_dly_q;
    assign ncs_rise   = ncs_s & ~ncs_dly_q;
    assign ncs_fall   = ~ncs_s & ncs_dly_q;
    assign frame_addr = shreg_q[NUM_BITS-2 -: 7];
    assign frame_data = shreg_q[7:0];
    assign write_ok   = (cnt_q == CW'(NUM_BITS)) && !overrun_q && shreg_q[NUM_BITS-1]
                        && (frame_addr <= MAX_ADDR_W) && (frame_addr <= 7'd4);

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  spi.ncs};
        sclk_dly_d  = sclk_s;
        copi_dly_d  = copi_sync_q[SYNC_STAGES-1];
        ncs_dly_d   = ncs_s;
        settle_d    = (settle_q == SW'(SYNC_STAGES)) ? settle_q : settle_q + 1'b1;
        // Only trust ncs once the reset-value idle pattern has flushed out of the chain,
        // so a select already low at reset release cannot start a frame.
        armed_d     = armed_q | ((settle_q == SW'(SYNC_STAGES)) && ncs_s);
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        overrun_d   = overrun_q;
        regs_d      = regs_q;

        case (state_q)
            IDLE: begin
                if (armed_q && ncs_fall) begin
                    cnt_d     = '0;
                    shreg_d   = '0;
                    overrun_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    if (cnt_q < CW'(NUM_BITS)) begin
                        shreg_d = {shreg_q[NUM_BITS-2:0], copi_dly_q};
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (write_ok) begin
                    for (int i = 0; i < 5; i++) begin
                        if (frame_addr == 7'(i)) regs_d[i] = frame_data;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_dly_q  <= 1'b0;
            copi_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            overrun_q   <= 1'b0;
            regs_q      <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            copi_dly_q  <= copi_dly_d;
            ncs_dly_q   <= ncs_dly_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            overrun_q   <= overrun_d;
            regs_q      <= regs_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - directed self-checking bench for spi_reg_peripheral
module tb_spi_reg_peripheral;
    logic       clk;
    logic       rst_n;
    logic [7:0] r0, r1, r2, r3, r4;
    int         checks;
    int         failures;

    spi_reg_peripheral_if spi_if ();

    spi_reg_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi_if),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        check_val({tag, "_r0"}, r0, e0);
        check_val({tag, "_r1"}, r1, e1);
        check_val({tag, "_r2"}, r2, e2);
        check_val({tag, "_r3"}, r3, e3);
        check_val({tag, "_r4"}, r4, e4);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCLK = clk/10: copi set, 5 clk low, 5 clk high; bits beyond 16 are zero
    task automatic spi_bits(input logic [15:0] val, input int nbits);
        logic [15:0] v;
        v = val;
        for (int k = 0; k < nbits; k++) begin
            spi_if.copi = (k < 16) ? v[15-k] : 1'b0;
            tick(5);
            spi_if.sclk = 1'b1;
            tick(5);
            spi_if.sclk = 1'b0;
        end
    endtask

    // Returns at the negedge after the 4th posedge following ncs rising
    task automatic send_frame(input logic [15:0] val, input int nbits);
        spi_if.ncs = 1'b0;
        tick(5);
        spi_bits(val, nbits);
        tick(5);
        spi_if.ncs = 1'b1;
        tick(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        spi_if.sclk = 1'b0;
        spi_if.copi = 1'b0;
        spi_if.ncs  = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        send_frame(16'h80F0, 16);
        check_val("lat_out0", r0, 8'hF0);
        send_frame(16'h84CC, 16);
        check_val("lat_duty", r4, 8'hCC);
        check_regs("basic", 8'hF0, 8'h00, 8'h00, 8'h00, 8'hCC);

        #2 rst_n = 1'b0;
        #1 check_regs("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(5);

        send_frame(16'h80F0, 16);
        send_frame(16'h0155, 16);
        check_regs("rd_frame", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(16'h8512, 16);
        check_regs("addr5", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(16'hFFAA, 16);
        check_regs("addr7f", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);

        send_frame(16'h83A5, 15);
        check_val("short15", r3, 8'h00);
        send_frame(16'h83A5, 17);
        check_val("long17", r3, 8'h00);
        spi_if.ncs = 1'b0;
        tick(10);
        spi_if.ncs = 1'b1;
        tick(4);
        check_val("no_sclk", r3, 8'h00);
        send_frame(16'h83A5, 16);
        check_regs("len_ok", 8'hF0, 8'h00, 8'h00, 8'hA5, 8'h00);

        send_frame(16'h8011, 16);
        send_frame(16'h8122, 16);
        send_frame(16'h8233, 16);
        send_frame(16'h8344, 16);
        send_frame(16'h8455, 16);
        check_regs("b2b", 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);

        spi_if.ncs = 1'b0;
        tick(5);
        spi_bits(16'h8277, 8);
        rst_n = 1'b0;
        #1 check_regs("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(2);
        rst_n = 1'b1;
        spi_bits(16'h7700, 8);
        tick(5);
        spi_if.ncs = 1'b1;
        tick(4);
        check_regs("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(16'h8277, 16);
        check_regs("refill", 8'h00, 8'h00, 8'h77, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI mode-0 target that writes the five control registers of the onboarding top-level.
- The registers drive output enables, PWM enables and the PWM duty cycle.
- Sits directly upstream of the PWM generator. Its SPI pins come straight from ui_in (SCLK=ui_in[0], COPI=ui_in[1], nCS=ui_in[2]) and are asynchronous to clk.
- Write-only. No CIPO is driven.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizers on sclk, copi and ncs (minimum 2)
MAX_ADDR, 4, highest writable register address; writes above it are discarded
NUM_BITS, 16, bits per frame: 1 R/W bit, 7-bit address, 8-bit data

Ports:
clk  input  1  system clock (10 MHz nominal); sole clock domain
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, asynchronous, idle low
copi  input  1  SPI data in, asynchronous
ncs  input  1  SPI chip select, active low, asynchronous
en_reg_out_7_0  output  8  register 0x00: uo_out enables
en_reg_out_15_8  output  8  register 0x01: uio_out enables
en_reg_pwm_7_0  output  8  register 0x02: PWM select for uo_out
en_reg_pwm_15_8  output  8  register 0x03: PWM select for uio_out
pwm_duty_cycle  output  8  register 0x04: duty cycle, 0x00 = 0 %, 0xFF = 100 %

Behaviour:
- Reset (rst_n low, asynchronous):
  - All five registers go to 0x00.
  - Synchronizer stages load their idle values: sclk 0, copi 0, ncs 1.
  - Shift register and bit counter are cleared. FSM goes to IDLE.
- Synchronization:
  - Each of sclk, copi and ncs passes through SYNC_STAGES flip-flops.
  - One extra flip-flop on each line provides edge detection.
  - An edge is acted on exactly once, in the clk cycle after the last sync stage changes.
- FSM states:
  - IDLE: on a synchronized ncs falling edge, clear the counter and shift register, then go to SHIFT.
  - SHIFT: on each sclk rising edge with counter < NUM_BITS, shift copi in MSB-first and increment the counter. Once the counter reaches 16 it saturates; further edges do not shift. On an ncs rising edge, go to COMMIT.
  - COMMIT (one cycle): perform the write if and only if all of the following hold, then return to IDLE:
    - counter == 16
    - frame[15] == 1 (write)
    - frame[14:8] <= MAX_ADDR
- Rejected frames leave all registers unchanged. This covers reads (bit15 = 0), short frames, overlong frames and bad addresses.
- Overlong frame rule: once the counter saturates, any further sclk rising edge sets an overrun flag. The frame is discarded in COMMIT if the flag is set.
- Latency: the written register shows its new value at most SYNC_STAGES+2 clk cycles after the physical ncs rising edge.
- The write is a full 8-bit replace. There are no partial writes.
- Simultaneous sclk and ncs rising edges in the same clk cycle: the ncs edge wins and the sclk edge is ignored.
- sclk edges while in IDLE, or while ncs is high, are ignored.
- If ncs is already low when reset is released, no frame starts until ncs goes high and then low again.
- Reset mid-frame clears everything immediately. The partial frame is lost and no register changes.
- SCLK requirement: high and low times must each be at least SYNC_STAGES+1 clk periods (SCLK ≤ clk/6 at default). Faster SCLK is out of spec.
- Outputs are direct register outputs. There is no combinational path from SPI pins to outputs.

Test Plan:
- Reset check: assert rst_n=0 mid-simulation with ncs high -> all five outputs read 0x00 immediately, without waiting for a clk edge.
- Basic write: write frames 0x80F0 and then 0x84CC, at SCLK = clk/10 -> en_reg_out_7_0 = 0xF0 and pwm_duty_cycle = 0xCC. Each value appears within 4 clk cycles of its ncs rising edge. All other registers stay 0x00.
- Rejected frames: each of the following leaves all registers unchanged:
  - read frame 0x0155 (bit15 = 0)
  - write to address 0x05 (frame 0x8512)
  - address 0x7F (frame 0xFFAA)
- Frame length: the following are all discarded:
  - a 15-bit frame (ncs raised early)
  - a 17-bit frame
  - ncs pulsed low with no SCLK edges
  Then a correct 16-bit frame 0x83A5 is accepted: en_reg_pwm_15_8 = 0xA5.
- Back-to-back writes: five writes to addresses 0x00–0x04 with data 0x11, 0x22, 0x33, 0x44, 0x55, with ncs high for only 4 clk cycles between frames -> all five registers hold their values.
- Reset mid-frame: rst_n pulsed low after 8 bits of frame 0x8277 -> no register changes. With ncs still low at release, the remaining bits are ignored. The next full frame 0x8277 sets en_reg_pwm_7_0 = 0x77.
